// File: rtl/mmio_rr_arbiter_pkg.sv
// Shared types and widths for the MMIO round-robin arbiter and its tag FIFO.
// The bus widths match the SoC driver's user port.
package mmio_rr_arbiter_pkg;

  localparam int MMIO_ADDR_WIDTH = 32;
  localparam int MMIO_DATA_WIDTH = 64;

  typedef enum logic {
    ARB_CMD_READ  = 1'b0,
    ARB_CMD_WRITE = 1'b1
  } arb_cmd_e;

  typedef logic [MMIO_ADDR_WIDTH-1:0] mmio_addr_t;
  typedef logic [MMIO_DATA_WIDTH-1:0] mmio_data_t;

  typedef struct packed {
    arb_cmd_e   cmd;
    mmio_addr_t addr;
    mmio_data_t wdata;
  } mmio_cmd_t;

endpackage

// File: rtl/mmio_rr_arbiter_if.sv
// Requester-side and downstream-side signals of the arbiter in one bundle.
// The slave modport is the arbiter's view; master is the surrounding masters plus driver.
interface mmio_rr_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import mmio_rr_arbiter_pkg::*;

  logic [NUM_REQ-1:0]                 req_val;
  logic [NUM_REQ-1:0]                 req_rdy;
  logic [NUM_REQ-1:0]                 req_cmd;
  logic [NUM_REQ*MMIO_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*MMIO_DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]                 rsp_val;
  mmio_data_t                         rsp_data;

  logic       dn_val;
  logic       dn_rdy;
  logic       dn_cmd;
  mmio_addr_t dn_addr;
  mmio_data_t dn_wdata;
  logic       dn_rsp_val;
  mmio_data_t dn_rsp_data;

  modport slave (
    input  req_val, req_cmd, req_addr, req_wdata,
    output req_rdy, rsp_val, rsp_data,
    output dn_val, dn_cmd, dn_addr, dn_wdata,
    input  dn_rdy, dn_rsp_val, dn_rsp_data
  );

  modport master (
    output req_val, req_cmd, req_addr, req_wdata,
    input  req_rdy, rsp_val, rsp_data,
    input  dn_val, dn_cmd, dn_addr, dn_wdata,
    output dn_rdy, dn_rsp_val, dn_rsp_data
  );

endinterface

// File: rtl/mmio_rr_arbiter_tag_fifo.sv
// Synchronous FIFO with a head-of-queue read port and an occupancy count.
// Holds requester IDs for in-order response routing; usable for any narrow tag stream.
module mmio_rr_arbiter_tag_fifo #(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: every _d gets its hold value first, so no branch leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: non-blocking assignments make every register sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mmio_rr_arbiter.sv
// Round-robin arbiter sharing one downstream MMIO port among NUM_REQ masters.
// Winner IDs go into an in-order tag FIFO that steers each response back to its issuer.
module mmio_rr_arbiter
  import mmio_rr_arbiter_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int TAG_DEPTH = 8,
  parameter  int TAG_W     = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(TAG_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  mmio_rr_arbiter_if.slave   bus,
  input  logic               clear_err_i,
  output logic [CNT_W-1:0]   outstanding_o,
  output logic               err_orphan_o,
  output logic               busy_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
  mmio_cmd_t          cmd_q, cmd_d;
  logic [NUM_REQ-1:0] rsp_val_q, rsp_val_d;
  mmio_data_t         rsp_data_q, rsp_data_d;
  logic               err_q, err_d;

  logic [TAG_W:0]     pick;
  logic               win_found;
  logic [TAG_W-1:0]   win_idx;
  logic               grant;
  logic [NUM_REQ-1:0] req_rdy;

  logic [TAG_W-1:0]   fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty;
  logic               rsp_pop, rsp_orphan;

  // Returns {found, index}: first set bit at or above ptr, wrapping modulo NUM_REQ.
  // Scanning downward lets the nearest candidate overwrite farther ones.
  function automatic logic [TAG_W:0] rr_pick(input logic [NUM_REQ-1:0] val,
                                             input logic [TAG_W-1:0]   ptr);
    logic [TAG_W:0]   result;
    logic [TAG_W-1:0] cand;
    result = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = TAG_W'((int'(ptr) + i) % NUM_REQ);
      if (val[cand]) result = {1'b1, cand};
    end
    return result;
  endfunction

  assign pick      = rr_pick(bus.req_val, rr_ptr_q);
  assign win_found = pick[TAG_W];
  assign win_idx   = pick[TAG_W-1:0];
  assign grant     = (state_q == ST_IDLE) && win_found && !fifo_full;

  always_comb begin
    req_rdy = '0;
    if (grant) req_rdy[win_idx] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cmd_d    = cmd_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d     = ST_ISSUE;
          cmd_d.cmd   = arb_cmd_e'(bus.req_cmd[win_idx]);
          cmd_d.addr  = bus.req_addr[win_idx*MMIO_ADDR_WIDTH +: MMIO_ADDR_WIDTH];
          cmd_d.wdata = bus.req_wdata[win_idx*MMIO_DATA_WIDTH +: MMIO_DATA_WIDTH];
          rr_ptr_d    = (win_idx == TAG_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      ST_ISSUE: begin
        if (bus.dn_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Responses pop the oldest tag; one arriving with nothing outstanding is an orphan.
  assign rsp_pop    = bus.dn_rsp_val && !fifo_empty;
  assign rsp_orphan = bus.dn_rsp_val && fifo_empty;

  always_comb begin
    rsp_val_d  = '0;
    rsp_data_d = rsp_data_q;
    if (rsp_pop) begin
      rsp_val_d[fifo_head] = 1'b1;
      rsp_data_d           = bus.dn_rsp_data;
    end
    if (clear_err_i)     err_d = 1'b0;
    else if (rsp_orphan) err_d = 1'b1;
    else                 err_d = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      cmd_q      <= '{cmd: ARB_CMD_READ, addr: '0, wdata: '0};
      rsp_val_q  <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cmd_q      <= cmd_d;
      rsp_val_q  <= rsp_val_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
    end
  end

  mmio_rr_arbiter_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (grant),
    .push_data_i (win_idx),
    .pop_i       (rsp_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign bus.req_rdy  = req_rdy;
  assign bus.rsp_val  = rsp_val_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.dn_val   = (state_q == ST_ISSUE);
  assign bus.dn_cmd   = cmd_q.cmd;
  assign bus.dn_addr  = cmd_q.addr;
  assign bus.dn_wdata = cmd_q.wdata;

  assign outstanding_o = fifo_count;
  assign err_orphan_o  = err_q;
  assign busy_o        = (state_q == ST_ISSUE) || (fifo_count != '0);

endmodule

// File: tb/tb_mmio_rr_arbiter.sv
// Self-checking bench for mmio_rr_arbiter: a vector table, hand-written corner
// sequences, and a randomized run against a queue-based reference model.
module tb_mmio_rr_arbiter;
  import mmio_rr_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int AW    = MMIO_ADDR_WIDTH;
  localparam int DW    = MMIO_DATA_WIDTH;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    clear_err = 1'b0;
  logic [$clog2(DEPTH):0]  outstanding;
  logic                    err_orphan;
  logic                    busy;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_rr_arbiter_if #(.NUM_REQ(N)) bus ();

  mmio_rr_arbiter #(.NUM_REQ(N), .TAG_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .clear_err_i   (clear_err),
    .outstanding_o (outstanding),
    .err_orphan_o  (err_orphan),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  // Reference model: outstanding requester IDs in issue order, next-search start,
  // whether a command is waiting downstream, and the sticky orphan flag.
  int             m_q[$];
  int             m_rr;
  bit             m_pend;
  bit             m_err;
  logic           m_cmd;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_wdata;

  typedef struct {
    logic [N-1:0] req_val;
    logic         dn_rdy;
    logic         rsp;
    logic         clr;
    logic [DW-1:0] data;
    logic [N-1:0] exp_rdy;
    logic         exp_dnval;
    int           exp_out;
    logic [N-1:0] exp_rsp;
    logic         exp_err;
  } vec_t;

  vec_t vecs[11];
  int   drain_exp[8] = '{1, 2, 3, 0, 1, 2, 3, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh2idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_req(input int idx, input logic cmd, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
    bus.req_cmd[idx]               = cmd;
    bus.req_addr[idx*AW +: AW]     = addr;
    bus.req_wdata[idx*DW +: DW]    = wdata;
  endtask

  task automatic idle_inputs();
    bus.req_val     = '0;
    bus.req_cmd     = '0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.dn_rdy      = 1'b0;
    bus.dn_rsp_val  = 1'b0;
    bus.dn_rsp_data = '0;
    clear_err       = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    m_q.delete();
    m_rr   = 0;
    m_pend = 1'b0;
    m_err  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic issue_one(input int idx);
    bit got = 1'b0;
    bus.req_val = '0;
    bus.req_val[idx] = 1'b1;
    bus.dn_rdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.req_rdy[idx]) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check($sformatf("issue_req%0d", idx), got, 1);
    step();
    bus.req_val = '0;
    step();
  endtask

  task automatic respond(input logic [DW-1:0] data, input int exp_idx, input string name);
    logic [N-1:0] exp_oh;
    exp_oh = '0;
    exp_oh[exp_idx] = 1'b1;
    bus.dn_rsp_val  = 1'b1;
    bus.dn_rsp_data = data;
    step();
    bus.dn_rsp_val  = 1'b0;
    check({name, "_rsp_val"}, bus.rsp_val, exp_oh);
    check({name, "_rsp_data"}, bus.rsp_data, data);
  endtask

  task automatic rand_cycle();
    logic [N-1:0]  rv, exp_rdy, exp_rsp;
    logic          rdy_in, rsp_in, clr_in, orphan;
    logic [DW-1:0] rdata;
    logic [AW-1:0] a[N];
    logic [DW-1:0] d[N];
    logic          c[N];
    int            w, t;
    rv     = N'($urandom_range(0, (1 << N) - 1));
    rdy_in = 1'($urandom_range(0, 1));
    rsp_in = ($urandom_range(0, 3) == 0);
    clr_in = ($urandom_range(0, 15) == 0);
    rdata  = {$urandom, $urandom};
    for (int i = 0; i < N; i++) begin
      a[i] = $urandom;
      d[i] = {$urandom, $urandom};
      c[i] = 1'($urandom_range(0, 1));
      set_req(i, c[i], a[i], d[i]);
    end
    bus.req_val     = rv;
    bus.dn_rdy      = rdy_in;
    bus.dn_rsp_val  = rsp_in;
    bus.dn_rsp_data = rdata;
    clear_err       = clr_in;

    w = -1;
    if (!m_pend && m_q.size() < DEPTH)
      for (int i = 0; i < N; i++)
        if (w < 0 && rv[(m_rr + i) % N]) w = (m_rr + i) % N;
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    #1 check("rand_req_rdy", bus.req_rdy, exp_rdy);

    @(posedge clk);
    exp_rsp = '0;
    orphan  = rsp_in && (m_q.size() == 0);
    if (rsp_in && !orphan) begin
      t = m_q.pop_front();
      exp_rsp[t] = 1'b1;
    end
    if (clr_in)      m_err = 1'b0;
    else if (orphan) m_err = 1'b1;
    if (w >= 0) begin
      m_pend  = 1'b1;
      m_cmd   = c[w];
      m_addr  = a[w];
      m_wdata = d[w];
      m_q.push_back(w);
      m_rr = (w + 1) % N;
    end else if (m_pend && rdy_in) begin
      m_pend = 1'b0;
    end

    #1;
    check("rand_dn_val", bus.dn_val, m_pend);
    if (m_pend) begin
      check("rand_dn_cmd", bus.dn_cmd, m_cmd);
      check("rand_dn_addr", bus.dn_addr, m_addr);
      check("rand_dn_wdata", bus.dn_wdata, m_wdata);
    end
    check("rand_outstanding", outstanding, m_q.size());
    check("rand_rsp_val", bus.rsp_val, exp_rsp);
    if (exp_rsp != '0) check("rand_rsp_data", bus.rsp_data, rdata);
    check("rand_err_orphan", err_orphan, m_err);
    check("rand_busy", busy, m_pend || (m_q.size() != 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants[$];
    int n;

    // req_val rdy rsp clr data | exp_rdy dn_val out rsp_val err
    vecs[0]  = '{4'hF, 1'b0, 1'b0, 1'b0, 64'h0,  4'h1, 1'b1, 1, 4'h0, 1'b0};
    vecs[1]  = '{4'hF, 1'b1, 1'b0, 1'b0, 64'h0,  4'h0, 1'b0, 1, 4'h0, 1'b0};
    vecs[2]  = '{4'h9, 1'b1, 1'b0, 1'b0, 64'h0,  4'h8, 1'b1, 2, 4'h0, 1'b0};
    vecs[3]  = '{4'h9, 1'b1, 1'b1, 1'b0, 64'h11, 4'h0, 1'b0, 1, 4'h1, 1'b0};
    vecs[4]  = '{4'h6, 1'b1, 1'b0, 1'b0, 64'h0,  4'h2, 1'b1, 2, 4'h0, 1'b0};
    vecs[5]  = '{4'h6, 1'b1, 1'b1, 1'b0, 64'h22, 4'h0, 1'b0, 1, 4'h8, 1'b0};
    vecs[6]  = '{4'h6, 1'b1, 1'b1, 1'b0, 64'h33, 4'h4, 1'b1, 1, 4'h2, 1'b0};
    vecs[7]  = '{4'h0, 1'b1, 1'b1, 1'b0, 64'h44, 4'h0, 1'b0, 0, 4'h4, 1'b0};
    vecs[8]  = '{4'h1, 1'b1, 1'b1, 1'b0, 64'h55, 4'h1, 1'b1, 1, 4'h0, 1'b1};
    vecs[9]  = '{4'h0, 1'b1, 1'b0, 1'b1, 64'h0,  4'h0, 1'b0, 1, 4'h0, 1'b0};
    vecs[10] = '{4'h0, 1'b1, 1'b1, 1'b0, 64'h66, 4'h0, 1'b0, 0, 4'h1, 1'b0};

    idle_inputs();
    step();
    check("reset_dn_val", bus.dn_val, 0);
    check("reset_dn_cmd", bus.dn_cmd, 0);
    check("reset_dn_addr", bus.dn_addr, 0);
    check("reset_dn_wdata", bus.dn_wdata, 0);
    check("reset_rsp_val", bus.rsp_val, 0);
    check("reset_rsp_data", bus.rsp_data, 0);
    check("reset_outstanding", outstanding, 0);
    check("reset_err_orphan", err_orphan, 0);
    check("reset_busy", busy, 0);

    // Vector table, applied back to back from reset.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      bus.req_val     = vecs[i].req_val;
      bus.dn_rdy      = vecs[i].dn_rdy;
      bus.dn_rsp_val  = vecs[i].rsp;
      bus.dn_rsp_data = vecs[i].data;
      clear_err       = vecs[i].clr;
      #1 check($sformatf("vec%0d_req_rdy", i), bus.req_rdy, vecs[i].exp_rdy);
      step();
      check($sformatf("vec%0d_dn_val", i), bus.dn_val, vecs[i].exp_dnval);
      check($sformatf("vec%0d_outstanding", i), outstanding, vecs[i].exp_out);
      check($sformatf("vec%0d_rsp_val", i), bus.rsp_val, vecs[i].exp_rsp);
      check($sformatf("vec%0d_err", i), err_orphan, vecs[i].exp_err);
      if (vecs[i].exp_rsp != '0)
        check($sformatf("vec%0d_rsp_data", i), bus.rsp_data, vecs[i].data);
    end
    idle_inputs();

    // Single requester write and its response.
    do_reset();
    set_req(2, ARB_CMD_WRITE, 32'h3000, 64'hA);
    bus.req_val = 4'b0100;
    bus.dn_rdy  = 1'b1;
    #1 check("single_req_rdy", bus.req_rdy, 4'b0100);
    step();
    bus.req_val = '0;
    check("single_dn_val", bus.dn_val, 1);
    check("single_dn_addr", bus.dn_addr, 32'h3000);
    check("single_dn_cmd", bus.dn_cmd, 1);
    check("single_dn_wdata", bus.dn_wdata, 64'hA);
    step();
    check("single_dn_val_drop", bus.dn_val, 0);
    respond(64'hFACEFEEDCAFEBABE, 2, "single");
    check("single_outstanding", outstanding, 0);
    step();
    check("single_rsp_one_cycle", bus.rsp_val, 0);

    // Fairness with all requesters active, running straight into a full tag FIFO.
    do_reset();
    bus.req_val = 4'hF;
    bus.dn_rdy  = 1'b1;
    for (int c = 0; c < 40 && grants.size() < 8; c++) begin
      #1;
      if (bus.req_rdy != '0) grants.push_back(oh2idx(bus.req_rdy));
      step();
    end
    check("fair_grant_count", grants.size(), 8);
    for (int k = 0; k < grants.size(); k++)
      check($sformatf("fair_grant%0d", k), grants[k], k % N);
    check("full_outstanding", outstanding, DEPTH);
    repeat (3) begin
      #1 check("full_no_rdy", bus.req_rdy, 0);
      step();
    end
    bus.dn_rsp_val  = 1'b1;
    bus.dn_rsp_data = 64'hAB;
    #1 check("full_no_rdy_at_pop", bus.req_rdy, 0);
    step();
    bus.dn_rsp_val = 1'b0;
    check("full_pop_rsp_val", bus.rsp_val, 4'b0001);
    check("full_pop_outstanding", outstanding, DEPTH - 1);
    n = 0;
    repeat (6) begin
      #1;
      if (bus.req_rdy != '0) n++;
      step();
    end
    check("full_one_more_grant", n, 1);
    check("full_refilled", outstanding, DEPTH);
    bus.req_val = '0;
    for (int k = 0; k < 8; k++) begin
      bus.dn_rsp_val  = 1'b1;
      bus.dn_rsp_data = 64'h100 + 64'(k);
      step();
      check($sformatf("drain%0d_rsp_val", k), bus.rsp_val, 4'b0001 << drain_exp[k]);
      check($sformatf("drain%0d_rsp_data", k), bus.rsp_data, 64'h100 + 64'(k));
    end
    bus.dn_rsp_val = 1'b0;
    step();
    check("drain_rsp_one_cycle", bus.rsp_val, 0);
    check("drain_outstanding", outstanding, 0);
    check("drain_busy", busy, 0);

    // Out-of-order issuers, responses routed in issue order.
    do_reset();
    issue_one(1);
    issue_one(3);
    issue_one(0);
    check("ooo_outstanding", outstanding, 3);
    respond(64'hD1, 1, "ooo_d1");
    respond(64'hD2, 3, "ooo_d2");
    respond(64'hD3, 0, "ooo_d3");
    check("ooo_outstanding_end", outstanding, 0);

    // Downstream stall, reset in the middle of it, then orphan handling.
    do_reset();
    set_req(1, ARB_CMD_READ, 32'h1234, 64'h5);
    bus.req_val = 4'b0010;
    #1 check("stall_req_rdy", bus.req_rdy, 4'b0010);
    step();
    bus.req_val = '0;
    set_req(1, ARB_CMD_WRITE, 32'hDEAD, 64'h9);
    for (int c = 0; c < 20; c++) begin
      check("stall_dn_val", bus.dn_val, 1);
      check("stall_dn_addr", bus.dn_addr, 32'h1234);
      step();
    end
    #2 rst = 1'b1;
    #1;
    check("stall_rst_dn_val", bus.dn_val, 0);
    check("stall_rst_outstanding", outstanding, 0);
    check("stall_rst_busy", busy, 0);
    step();
    rst = 1'b0;
    bus.dn_rsp_val  = 1'b1;
    bus.dn_rsp_data = 64'h77;
    step();
    bus.dn_rsp_val = 1'b0;
    check("orphan_err", err_orphan, 1);
    check("orphan_no_rsp", bus.rsp_val, 0);
    check("orphan_outstanding", outstanding, 0);
    bus.dn_rsp_val = 1'b1;
    clear_err      = 1'b1;
    step();
    bus.dn_rsp_val = 1'b0;
    clear_err      = 1'b0;
    check("orphan_clear_priority", err_orphan, 0);
    check("orphan_clear_no_rsp", bus.rsp_val, 0);
    step();
    check("orphan_stays_clear", err_orphan, 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) rand_cycle();
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
